// File: rtl/op_selector_pipe.sv
// Two-operand source selector for a PE ALU. It waits for neighbour and bus data and holds the result in a one-entry output register.
// Define OPSEL_STALL_CNT_EN to build in the saturating WAIT-cycle counter; otherwise stall_cnt is tied to zero.
module op_selector_pipe #(
   parameter int LEN   = 16,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       sel_a,
   input  logic [2:0]       sel_b,
   input  logic [LEN-1:0]   weight,
   input  logic [LEN-1:0]   data,
   input  logic [LEN-1:0]   gradient,
   input  logic [LEN-1:0]   interim,
   input  logic [LEN-1:0]   meta,
   input  logic [LEN-1:0]   neigh,
   input  logic             neigh_valid,
   output logic             neigh_ack,
   input  logic [LEN-1:0]   bus,
   input  logic             bus_valid,
   output logic             bus_ack,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [LEN-1:0]   out_a,
   output logic [LEN-1:0]   out_b,
   input  logic             stall_clr,
   output logic [CNT_W-1:0] stall_cnt
);
   typedef enum logic [0:0] {IDLE = 1'b0, WAIT = 1'b1} state_t;
   localparam logic [2:0] SEL_NEIGH = 3'd6;
   localparam logic [2:0] SEL_BUS   = 3'd7;

   state_t         state_r, state_nxt_s;
   logic [2:0]     sel_a_r, sel_b_r, cur_sel_a_s, cur_sel_b_s;
   logic [LEN-1:0] stage_a_r, stage_b_r, neigh_r, bus_r, out_a_r, out_b_r;
   logic [LEN-1:0] loc_a_s, loc_b_s, neigh_eff_s, bus_eff_s, op_a_s, op_b_s;
   logic           pend_n_r, pend_b_r, out_valid_r;
   logic           slot_free_s, in_ready_s, accept_s, want_n_s, want_b_s;
   logic           ack_n_s, ack_b_s, rem_n_s, rem_b_s, load_s;

   function automatic logic [LEN-1:0] pick_local(input logic [2:0] sel, input logic [LEN-1:0] w,
                                                 input logic [LEN-1:0] d, input logic [LEN-1:0] g,
                                                 input logic [LEN-1:0] i, input logic [LEN-1:0] m);
      case (sel)
         3'd1:    pick_local = w;
         3'd2:    pick_local = d;
         3'd3:    pick_local = g;
         3'd4:    pick_local = i;
         3'd5:    pick_local = m;
         default: pick_local = {LEN{1'b0}};
      endcase
   endfunction

   function automatic logic [LEN-1:0] resolve(input logic [2:0] sel, input logic [LEN-1:0] loc,
                                              input logic [LEN-1:0] nv, input logic [LEN-1:0] bv);
      case (sel)
         SEL_NEIGH: resolve = nv;
         SEL_BUS:   resolve = bv;
         default:   resolve = loc;
      endcase
   endfunction

   // Handshakes, capture decisions and next state; acceptance-cycle acks are qualified by the accept itself.
   always_comb begin
      slot_free_s = !out_valid_r || out_ready;
      in_ready_s  = (state_r == IDLE) && slot_free_s;
      accept_s    = in_valid && in_ready_s && !reset;
      if (state_r == IDLE) begin
         want_n_s    = accept_s && ((sel_a == SEL_NEIGH) || (sel_b == SEL_NEIGH));
         want_b_s    = accept_s && ((sel_a == SEL_BUS) || (sel_b == SEL_BUS));
         cur_sel_a_s = sel_a;
         cur_sel_b_s = sel_b;
         loc_a_s     = pick_local(sel_a, weight, data, gradient, interim, meta);
         loc_b_s     = pick_local(sel_b, weight, data, gradient, interim, meta);
      end else begin
         want_n_s    = pend_n_r;
         want_b_s    = pend_b_r;
         cur_sel_a_s = sel_a_r;
         cur_sel_b_s = sel_b_r;
         loc_a_s     = stage_a_r;
         loc_b_s     = stage_b_r;
      end
      ack_n_s     = want_n_s && neigh_valid && !reset;
      ack_b_s     = want_b_s && bus_valid && !reset;
      rem_n_s     = want_n_s && !neigh_valid;
      rem_b_s     = want_b_s && !bus_valid;
      neigh_eff_s = ack_n_s ? neigh : neigh_r;
      bus_eff_s   = ack_b_s ? bus : bus_r;
      op_a_s      = resolve(cur_sel_a_s, loc_a_s, neigh_eff_s, bus_eff_s);
      op_b_s      = resolve(cur_sel_b_s, loc_b_s, neigh_eff_s, bus_eff_s);
      load_s      = ((state_r == WAIT) || accept_s) && !rem_n_s && !rem_b_s && slot_free_s;
      case (state_r)
         IDLE: begin
            if (accept_s && !load_s) state_nxt_s = WAIT;
            else                     state_nxt_s = IDLE;
         end
         WAIT: begin
            if (load_s) state_nxt_s = IDLE;
            else        state_nxt_s = WAIT;
         end
         default: state_nxt_s = IDLE;
      endcase
   end

   // FSM, pending flags and staging registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= IDLE;
         pend_n_r  <= 1'b0;
         pend_b_r  <= 1'b0;
         sel_a_r   <= 3'd0;
         sel_b_r   <= 3'd0;
         stage_a_r <= {LEN{1'b0}};
         stage_b_r <= {LEN{1'b0}};
         neigh_r   <= {LEN{1'b0}};
         bus_r     <= {LEN{1'b0}};
      end else begin
         state_r  <= state_nxt_s;
         pend_n_r <= rem_n_s;
         pend_b_r <= rem_b_s;
         if (accept_s) begin
            sel_a_r   <= sel_a;
            sel_b_r   <= sel_b;
            stage_a_r <= loc_a_s;
            stage_b_r <= loc_b_s;
         end
         if (ack_n_s) neigh_r <= neigh;
         if (ack_b_s) bus_r <= bus;
      end
   end

   // One-entry output register; a take and a load in the same cycle keeps it full.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out_valid_r <= 1'b0;
         out_a_r     <= {LEN{1'b0}};
         out_b_r     <= {LEN{1'b0}};
      end else if (load_s) begin
         out_valid_r <= 1'b1;
         out_a_r     <= op_a_s;
         out_b_r     <= op_b_s;
      end else if (out_ready) begin
         out_valid_r <= 1'b0;
      end
   end

   assign in_ready  = in_ready_s;
   assign neigh_ack = ack_n_s;
   assign bus_ack   = ack_b_s;
   assign out_valid = out_valid_r;
   assign out_a     = out_a_r;
   assign out_b     = out_b_r;

`ifdef OPSEL_STALL_CNT_EN
   logic [CNT_W-1:0] cnt_r;

   // Saturating count of WAIT cycles; clear wins over increment.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         cnt_r <= {CNT_W{1'b0}};
      else if (stall_clr)
         cnt_r <= {CNT_W{1'b0}};
      else if ((state_r == WAIT) && (cnt_r != {CNT_W{1'b1}}))
         cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
   end

   assign stall_cnt = cnt_r;
`else
   logic unused_clr_s;
   assign unused_clr_s = stall_clr;
   assign stall_cnt    = {CNT_W{1'b0}};
`endif
endmodule

// File: tb/tb_op_selector_pipe.sv
// Bench for op_selector_pipe: directed test-plan scenarios followed by random traffic.
// A transaction-level model is checked every cycle; literal checks pin the directed cases.
module tb_op_selector_pipe;
   localparam int LEN   = 16;
   localparam int CNT_W = 16;

   logic             clk, reset, in_valid, in_ready, neigh_valid, neigh_ack, bus_valid, bus_ack;
   logic             out_valid, out_ready, stall_clr;
   logic [2:0]       sel_a, sel_b;
   logic [LEN-1:0]   weight, data, gradient, interim, meta, neigh, bus, out_a, out_b;
   logic [CNT_W-1:0] stall_cnt;

   int n_vec = 0;
   int n_err = 0;

   op_selector_pipe #(.LEN(LEN), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .sel_a(sel_a), .sel_b(sel_b), .weight(weight), .data(data), .gradient(gradient),
      .interim(interim), .meta(meta), .neigh(neigh), .neigh_valid(neigh_valid),
      .neigh_ack(neigh_ack), .bus(bus), .bus_valid(bus_valid), .bus_ack(bus_ack),
      .out_valid(out_valid), .out_ready(out_ready), .out_a(out_a), .out_b(out_b),
      .stall_clr(stall_clr), .stall_cnt(stall_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [LEN-1:0] local_of(input logic [2:0] s);
      case (s)
         3'd1:    return weight;
         3'd2:    return data;
         3'd3:    return gradient;
         3'd4:    return interim;
         3'd5:    return meta;
         default: return 16'h0000;
      endcase
   endfunction

   // Model: one instruction in flight with a set of still-missing external sources, plus an output slot.
   bit             busy, need_n, need_b, mo_valid;
   logic [2:0]     m_sa, m_sb;
   logic [LEN-1:0] m_va, m_vb, mo_a, mo_b;
   int             m_wait;

   always @(negedge clk) begin
      bit slot, e_rdy, acc, e_nack, e_back, was_wait, ld;
      if (reset) begin
         busy = 0; need_n = 0; need_b = 0; mo_valid = 0; mo_a = '0; mo_b = '0; m_wait = 0;
      end
      check("out_valid", {31'd0, out_valid}, {31'd0, mo_valid});
      if (mo_valid) begin
         check("out_a", {16'd0, out_a}, {16'd0, mo_a});
         check("out_b", {16'd0, out_b}, {16'd0, mo_b});
      end
`ifdef OPSEL_STALL_CNT_EN
      check("stall_cnt", {16'd0, stall_cnt}, m_wait);
`else
      check("stall_cnt", {16'd0, stall_cnt}, 32'd0);
`endif
      slot  = !mo_valid || out_ready;
      e_rdy = !busy && slot;
      acc   = in_valid && e_rdy && !reset;
      was_wait = busy;
      if (acc) begin
         m_sa = sel_a; m_sb = sel_b;
         m_va = local_of(sel_a); m_vb = local_of(sel_b);
         need_n = (sel_a == 3'd6) || (sel_b == 3'd6);
         need_b = (sel_a == 3'd7) || (sel_b == 3'd7);
      end
      e_nack = need_n && neigh_valid && !reset;
      e_back = need_b && bus_valid && !reset;
      check("in_ready", {31'd0, in_ready}, {31'd0, e_rdy});
      check("neigh_ack", {31'd0, neigh_ack}, {31'd0, e_nack});
      check("bus_ack", {31'd0, bus_ack}, {31'd0, e_back});
      if (e_nack) begin
         if (m_sa == 3'd6) m_va = neigh;
         if (m_sb == 3'd6) m_vb = neigh;
         need_n = 0;
      end
      if (e_back) begin
         if (m_sa == 3'd7) m_va = bus;
         if (m_sb == 3'd7) m_vb = bus;
         need_b = 0;
      end
      ld = (busy || acc) && !need_n && !need_b && slot;
      if (ld) begin
         mo_valid = 1; mo_a = m_va; mo_b = m_vb;
      end else if (out_ready) begin
         mo_valid = 0;
      end
      busy = (busy || acc) && !ld;
      if (reset || stall_clr) m_wait = 0;
      else if (was_wait && m_wait < 65535) m_wait = m_wait + 1;
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; sel_a = 3'd0; sel_b = 3'd0;
      weight = 16'h0; data = 16'h0; gradient = 16'h0; interim = 16'h0; meta = 16'h0;
      neigh = 16'h0; neigh_valid = 1'b1; bus = 16'h0; bus_valid = 1'b1;
      out_ready = 1'b0; stall_clr = 1'b0;
      @(negedge clk);
      check("rst in_ready", {31'd0, in_ready}, 32'd1);
      check("rst out_valid", {31'd0, out_valid}, 32'd0);
      check("rst acks", {30'd0, neigh_ack, bus_ack}, 32'd0);
      check("rst stall_cnt", {16'd0, stall_cnt}, 32'd0);
      cyc();
      reset = 1'b0; neigh_valid = 1'b0; bus_valid = 1'b0;
      cyc();

      // Local only, four back-to-back instructions.
      out_ready = 1'b1; in_valid = 1'b1; sel_a = 3'd1; sel_b = 3'd5;
      weight = 16'h0011; meta = 16'h0055;
      repeat (4) cyc();
      in_valid = 1'b0;
      @(negedge clk);
      check("local out_a", {16'd0, out_a}, 32'h0011);
      check("local out_b", {16'd0, out_b}, 32'h0055);
      cyc();

      // Zero code.
      in_valid = 1'b1; sel_a = 3'd0; sel_b = 3'd3; gradient = 16'hBEEF;
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      check("zero out_a", {16'd0, out_a}, 32'h0000);
      check("zero out_b", {16'd0, out_b}, 32'hBEEF);
      stall_clr = 1'b1;
      cyc();
      stall_clr = 1'b0;

      // Neighbour wait: data must be the value present at acceptance.
      in_valid = 1'b1; sel_a = 3'd6; sel_b = 3'd2; data = 16'h5678;
      cyc();
      in_valid = 1'b0; data = 16'hFFFF;
      cyc();
      cyc();
      neigh_valid = 1'b1; neigh = 16'h1234;
      @(negedge clk);
      check("neigh ack", {31'd0, neigh_ack}, 32'd1);
      cyc();
      neigh_valid = 1'b0;
      @(negedge clk);
      check("neigh out_a", {16'd0, out_a}, 32'h1234);
      check("neigh out_b", {16'd0, out_b}, 32'h5678);
`ifdef OPSEL_STALL_CNT_EN
      check("neigh stall", {16'd0, stall_cnt}, 32'd3);
`else
      check("neigh stall", {16'd0, stall_cnt}, 32'd0);
`endif
      cyc();

      // Shared bus source, then both externals arriving together.
      in_valid = 1'b1; sel_a = 3'd7; sel_b = 3'd7; bus_valid = 1'b1; bus = 16'h00AA;
      @(negedge clk);
      check("bus ack", {31'd0, bus_ack}, 32'd1);
      cyc();
      in_valid = 1'b0; bus_valid = 1'b0;
      @(negedge clk);
      check("shared out_a", {16'd0, out_a}, 32'h00AA);
      check("shared out_b", {16'd0, out_b}, 32'h00AA);
      check("shared no 2nd ack", {31'd0, bus_ack}, 32'd0);
      cyc();
      in_valid = 1'b1; sel_a = 3'd6; sel_b = 3'd7;
      cyc();
      in_valid = 1'b0;
      cyc();
      neigh_valid = 1'b1; bus_valid = 1'b1; neigh = 16'h0101; bus = 16'h0202;
      @(negedge clk);
      check("dual acks", {30'd0, neigh_ack, bus_ack}, 32'd3);
      cyc();
      neigh_valid = 1'b0; bus_valid = 1'b0;
      @(negedge clk);
      check("dual out_a", {16'd0, out_a}, 32'h0101);
      check("dual out_b", {16'd0, out_b}, 32'h0202);
      cyc();

      // Back-pressure, then simultaneous take and load.
      out_ready = 1'b0; in_valid = 1'b1; sel_a = 3'd1; sel_b = 3'd1; weight = 16'h7777;
      cyc();
      weight = 16'h8888;
      @(negedge clk);
      check("bp in_ready", {31'd0, in_ready}, 32'd0);
      check("bp hold a", {16'd0, out_a}, 32'h7777);
      cyc();
      @(negedge clk);
      check("bp hold b", {16'd0, out_b}, 32'h7777);
      cyc();
      out_ready = 1'b1;
      @(negedge clk);
      check("bp release rdy", {31'd0, in_ready}, 32'd1);
      cyc();
      in_valid = 1'b0;
      @(negedge clk);
      check("bp reload valid", {31'd0, out_valid}, 32'd1);
      check("bp reload a", {16'd0, out_a}, 32'h8888);
      cyc();

      // Reset while waiting on the bus.
      in_valid = 1'b1; sel_a = 3'd7; sel_b = 3'd2; data = 16'h4242;
      cyc();
      in_valid = 1'b0;
      cyc();
      bus_valid = 1'b1; reset = 1'b1;
      @(negedge clk);
      check("rstw bus_ack", {31'd0, bus_ack}, 32'd0);
      check("rstw out_valid", {31'd0, out_valid}, 32'd0);
      check("rstw in_ready", {31'd0, in_ready}, 32'd1);
      check("rstw stall_cnt", {16'd0, stall_cnt}, 32'd0);
      cyc();
      reset = 1'b0; bus_valid = 1'b0;
      cyc();
      @(negedge clk);
      check("rstw after", {31'd0, out_valid}, 32'd0);
      cyc();

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         in_valid    = ($urandom_range(0, 3) != 0);
         sel_a       = 3'($urandom_range(0, 7));
         sel_b       = 3'($urandom_range(0, 7));
         weight      = 16'($urandom); data = 16'($urandom); gradient = 16'($urandom);
         interim     = 16'($urandom); meta = 16'($urandom);
         neigh       = 16'($urandom); bus = 16'($urandom);
         neigh_valid = ($urandom_range(0, 2) == 0);
         bus_valid   = ($urandom_range(0, 2) == 0);
         out_ready   = ($urandom_range(0, 3) != 0);
         stall_clr   = ($urandom_range(0, 19) == 0);
         reset       = ($urandom_range(0, 299) == 0);
         cyc();
      end
      reset = 1'b0;
      cyc();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
